rx_frame_classifier: RTL and testbench

RX_FRAME_CLASSIFIER -- requirements
Module: rx_frame_classifier

---
 rtl/rx_frame_classifier.sv | 224 ++++++++++++++++++++++
 tb/tb_rx_frame_classifier.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_classifier.sv
// rx_frame_classifier: splits each received Ethernet frame into a packed header word (length,
// FCS status, control flag, DA/SA/EtherType) and a delimited body byte stream, and counts
// dropped and forwarded MAC control frames.
module rx_frame_classifier #(
  parameter int unsigned MAX_LEN       = 1522,
  parameter int unsigned HEADER_DWIDTH = 128
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  input  logic                     rx_last,
  input  logic                     rx_err,
  output logic [HEADER_DWIDTH-1:0] h_fifo_din,
  output logic                     h_fifo_wren,
  input  logic                     h_fifo_full,
  output logic [8:0]               b_fifo_din,
  output logic                     b_fifo_wren,
  input  logic                     b_fifo_afull,
  output logic [15:0]              drop_cnt,
  output logic [15:0]              ctrl_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_BODY, S_DISCARD, S_COMMIT} state_e;

  // CRC-32 magic residue, stated MSB-first; the shift register below runs LSB-first.
  localparam logic [31:0] CrcResidue = 32'hC704DD7B;
  localparam logic [15:0] LastIdx    = 16'(MAX_LEN - 1);
  localparam logic [15:0] MaxLen16   = 16'(MAX_LEN);

  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_e                   state_q, state_d;
  logic [111:0]             hdr_q, hdr_d;     // DA, SA, EtherType shifted in byte by byte
  logic [31:0]              crc_q, crc_d;
  logic [15:0]              len_q, len_d;     // bytes accepted so far, saturating
  logic                     err_q, err_d;
  logic                     trunc_q, trunc_d;
  logic                     pend_q, pend_d;   // header commit owed after discarding the tail
  logic [15:0]              drop_q, drop_d;
  logic [15:0]              ctrl_q, ctrl_d;
  logic                     hwren_q, hwren_d;
  logic [HEADER_DWIDTH-1:0] hdin_q, hdin_d;
  logic                     bwren_q, bwren_d;
  logic [8:0]               bdin_q, bdin_d;

  logic                     is_ctrl;
  logic                     fcs_ok;
  logic [11:0]              len_field;
  logic [127:0]             hdr_word;

  assign is_ctrl   = (hdr_q[111:72] == 40'h0180C20000);
  assign fcs_ok    = (bitrev32(crc_q) == CrcResidue) && !err_q && !trunc_q &&
                     (len_q >= 16'd64) && (len_q <= MaxLen16);
  assign len_field = (len_q > 16'd4095) ? 12'hFFF : len_q[11:0];
  assign hdr_word  = {len_field, fcs_ok, is_ctrl, 2'b00, hdr_q};

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      hdr_q   <= '0;
      crc_q   <= 32'hFFFFFFFF;
      len_q   <= '0;
      err_q   <= 1'b0;
      trunc_q <= 1'b0;
      pend_q  <= 1'b0;
      drop_q  <= '0;
      ctrl_q  <= '0;
      hwren_q <= 1'b0;
      hdin_q  <= '0;
      bwren_q <= 1'b0;
      bdin_q  <= '0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      crc_q   <= crc_d;
      len_q   <= len_d;
      err_q   <= err_d;
      trunc_q <= trunc_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
      ctrl_q  <= ctrl_d;
      hwren_q <= hwren_d;
      hdin_q  <= hdin_d;
      bwren_q <= bwren_d;
      bdin_q  <= bdin_d;
    end
  end

  // Next-state, capture and FIFO write decisions.
  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    crc_d   = crc_q;
    len_d   = len_q;
    err_d   = err_q;
    trunc_d = trunc_q;
    pend_d  = pend_q;
    drop_d  = drop_q;
    ctrl_d  = ctrl_q;
    hwren_d = 1'b0;
    hdin_d  = hdin_q;
    bwren_d = 1'b0;
    bdin_d  = bdin_q;

    unique case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          // Back-pressure is only consulted here; a one-byte frame is too short to keep.
          if (h_fifo_full || b_fifo_afull || rx_last) begin
            drop_d = sat_inc(drop_q);
            pend_d = 1'b0;
            if (!rx_last) begin
              state_d = S_DISCARD;
            end
          end else begin
            hdr_d   = {104'h0, rx_data};
            crc_d   = crc_byte(32'hFFFFFFFF, rx_data);
            len_d   = 16'd1;
            err_d   = rx_err;
            trunc_d = 1'b0;
            pend_d  = 1'b0;
            state_d = S_HDR;
          end
        end
      end

      S_HDR: begin
        if (rx_valid) begin
          if (rx_last) begin
            drop_d  = sat_inc(drop_q);
            state_d = S_IDLE;
          end else begin
            hdr_d = {hdr_q[103:0], rx_data};
            crc_d = crc_byte(crc_q, rx_data);
            len_d = sat_inc(len_q);
            err_d = err_q | rx_err;
            if (len_q == 16'd13) begin
              state_d = S_BODY;
            end
          end
        end
      end

      S_BODY: begin
        if (rx_valid) begin
          crc_d   = crc_byte(crc_q, rx_data);
          len_d   = sat_inc(len_q);
          err_d   = err_q | rx_err;
          bwren_d = 1'b1;
          if (rx_last) begin
            bdin_d  = {1'b1, rx_data};
            state_d = S_COMMIT;
          end else if (len_q == LastIdx) begin
            // Oversize: close the body early, keep counting the tail for the header length.
            bdin_d  = {1'b1, rx_data};
            trunc_d = 1'b1;
            pend_d  = 1'b1;
            state_d = S_DISCARD;
          end else begin
            bdin_d = {1'b0, rx_data};
          end
        end
      end

      S_DISCARD: begin
        if (rx_valid) begin
          len_d = sat_inc(len_q);
          err_d = err_q | rx_err;
          if (rx_last) begin
            state_d = pend_q ? S_COMMIT : S_IDLE;
          end
        end
      end

      S_COMMIT: begin
        hwren_d = 1'b1;
        hdin_d  = HEADER_DWIDTH'(hdr_word);
        pend_d  = 1'b0;
        state_d = S_IDLE;
        if (is_ctrl) begin
          ctrl_d = sat_inc(ctrl_q);
        end
        // A byte arriving while the header is written starts a frame we cannot capture.
        if (rx_valid) begin
          drop_d = sat_inc(drop_q);
          if (!rx_last) begin
            state_d = S_DISCARD;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign h_fifo_din  = hdin_q;
  assign h_fifo_wren = hwren_q;
  assign b_fifo_din  = bdin_q;
  assign b_fifo_wren = bwren_q;
  assign drop_cnt    = drop_q;
  assign ctrl_cnt    = ctrl_q;

endmodule

// File: tb/tb_rx_frame_classifier.sv
// Self-checking bench for rx_frame_classifier: directed frames plus randomized traffic,
// scored against a frame-level reference model.
module tb_rx_frame_classifier;

  localparam int MaxLen = 1522;
  localparam int HdrW   = 128;

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      rx_data;
  logic            rx_valid;
  logic            rx_last;
  logic            rx_err;
  logic [HdrW-1:0] h_fifo_din;
  logic            h_fifo_wren;
  logic            h_fifo_full;
  logic [8:0]      b_fifo_din;
  logic            b_fifo_wren;
  logic            b_fifo_afull;
  logic [15:0]     drop_cnt;
  logic [15:0]     ctrl_cnt;

  rx_frame_classifier #(
    .MAX_LEN      (MaxLen),
    .HEADER_DWIDTH(HdrW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_last     (rx_last),
    .rx_err      (rx_err),
    .h_fifo_din  (h_fifo_din),
    .h_fifo_wren (h_fifo_wren),
    .h_fifo_full (h_fifo_full),
    .b_fifo_din  (b_fifo_din),
    .b_fifo_wren (b_fifo_wren),
    .b_fifo_afull(b_fifo_afull),
    .drop_cnt    (drop_cnt),
    .ctrl_cnt    (ctrl_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0]   frm[$];
  logic [8:0]   exp_b[$];
  logic [127:0] exp_h[$];
  int           exp_hc[$];
  int           exp_b_total = 0;
  int           exp_h_total = 0;
  int           obs_b = 0;
  int           obs_h = 0;
  int           m_drop = 0;
  int           m_ctrl = 0;
  bit           prev_commit = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Scoreboard: every body/header write is matched against the model's expectations.
  initial begin
    logic [8:0] eb;
    forever begin
      @(negedge clk);
      if (b_fifo_wren === 1'b1) begin
        obs_b++;
        if (exp_b.size() > 0) begin
          eb = exp_b.pop_front();
          check("body", 128'(b_fifo_din), 128'(eb));
        end
      end
      if (h_fifo_wren === 1'b1) begin
        obs_h++;
        if (exp_h.size() > 0) check("hdr", 128'(h_fifo_din), exp_h.pop_front());
        if (exp_hc.size() > 0) check("hdr_cycle", 128'(cyc), 128'(exp_hc.pop_front()));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

  // Standard Ethernet CRC-32 (reflected, init and final complement) over frm[0..n-1].
  function automatic logic [31:0] crc32(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, frm[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // kind: 0 unicast, 1 MAC control DA, 2 near-miss multicast DA (not control).
  task automatic build_frame(input int len, input int kind, input bit corrupt);
    logic [31:0] fcs;
    frm.delete();
    for (int i = 0; i < len; i++) frm.push_back(8'($urandom));
    if (len >= 6) begin
      if (kind == 0) begin
        frm[0] = frm[0] & 8'hFE;
      end else begin
        frm[0] = 8'h01; frm[1] = 8'h80; frm[2] = 8'hC2; frm[3] = 8'h00;
        frm[4] = (kind == 1) ? 8'h00 : 8'h01;
        frm[5] = 8'h01;
      end
    end
    if (kind == 1 && len >= 14) begin
      frm[12] = 8'h88;
      frm[13] = 8'h08;
    end
    if (len >= 18) begin
      fcs = crc32(len - 4);
      frm[len-4] = fcs[7:0];
      frm[len-3] = fcs[15:8];
      frm[len-2] = fcs[23:16];
      frm[len-1] = fcs[31:24];
      if (corrupt) frm[len/2] = frm[len/2] ^ 8'h10;
    end
  endtask

  // Reference model for one frame in frm; returns 1 when a header is expected.
  function automatic bit model(input bit blocked, input bit has_err);
    int           n;
    int           nb;
    bit           crc_ok;
    bit           ok;
    bit           ctrl;
    logic [111:0] h112;
    logic [11:0]  l12;
    n = frm.size();
    if (blocked || n < 15) begin
      m_drop = (m_drop < 65535) ? m_drop + 1 : m_drop;
      return 1'b0;
    end
    nb = (n < MaxLen) ? n : MaxLen;
    for (int i = 14; i < nb; i++) begin
      exp_b.push_back({(i == nb - 1) ? 1'b1 : 1'b0, frm[i]});
      exp_b_total++;
    end
    crc_ok = (n >= 4) && (crc32(n - 4) == {frm[n-1], frm[n-2], frm[n-3], frm[n-4]});
    ok     = crc_ok && !has_err && n >= 64 && n <= MaxLen;
    ctrl   = frm[0] == 8'h01 && frm[1] == 8'h80 && frm[2] == 8'hC2 &&
             frm[3] == 8'h00 && frm[4] == 8'h00;
    h112   = '0;
    for (int i = 0; i < 14; i++) h112 = (h112 << 8) | 112'(frm[i]);
    l12    = (n > 4095) ? 12'hFFF : 12'(n);
    exp_h.push_back({l12, ok, ctrl, 2'b00, h112});
    exp_h_total++;
    if (ctrl) m_ctrl = (m_ctrl < 65535) ? m_ctrl + 1 : m_ctrl;
    return 1'b1;
  endfunction

  task automatic idle(input int n);
    rx_valid     = 1'b0;
    rx_last      = 1'b0;
    rx_err       = 1'b0;
    h_fifo_full  = 1'b0;
    b_fifo_afull = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_byte(input logic [7:0] d, input bit last, input bit err,
                            input bit full, input bit afull);
    rx_valid     = 1'b1;
    rx_data      = d;
    rx_last      = last;
    rx_err       = err;
    h_fifo_full  = full;
    b_fifo_afull = afull;
    @(posedge clk);
    #1;
  endtask

  // Back-pressure flags are randomized after byte 0; they must have no effect there.
  task automatic send_frame(input bit full0, input bit afull0, input int err_idx,
                            input int bubble_pct, input bit commit);
    int n;
    n = frm.size();
    for (int i = 0; i < n; i++) begin
      if (i > 0 && bubble_pct > 0 && $urandom_range(99) < bubble_pct) idle(1);
      drive_byte(frm[i], i == n - 1, i == err_idx,
                 (i == 0) ? full0 : 1'($urandom), (i == 0) ? afull0 : 1'($urandom));
    end
    if (commit) exp_hc.push_back(cyc + 1);
    idle(0);
  endtask

  task automatic run_frame(input int len, input int kind, input bit corrupt, input bit full0,
                           input bit afull0, input int err_idx, input int gap,
                           input int bubble_pct);
    bit blocked;
    bit commit;
    idle(gap);
    build_frame(len, kind, corrupt);
    blocked = full0 || afull0 || (gap == 0 && prev_commit);
    commit  = model(blocked, err_idx >= 0 && err_idx < len);
    send_frame(full0, afull0, err_idx, bubble_pct, commit);
    prev_commit = commit;
  endtask

  task automatic settle(input string tag);
    idle(4);
    prev_commit = 1'b0;
    check({tag, "_drop_cnt"}, 128'(drop_cnt), 128'(m_drop));
    check({tag, "_ctrl_cnt"}, 128'(ctrl_cnt), 128'(m_ctrl));
    check({tag, "_body_pending"}, 128'(exp_b.size()), 128'(0));
    check({tag, "_hdr_pending"}, 128'(exp_h.size()), 128'(0));
  endtask

  initial begin
    int len;
    int kind;
    rst = 1'b1;
    rx_data = 8'h00;
    idle(3);
    @(negedge clk);
    check("rst_h_wren", 128'(h_fifo_wren), 128'(0));
    check("rst_b_wren", 128'(b_fifo_wren), 128'(0));
    check("rst_h_din", 128'(h_fifo_din), 128'(0));
    check("rst_b_din", 128'(b_fifo_din), 128'(0));
    check("rst_drop", 128'(drop_cnt), 128'(0));
    check("rst_ctrl", 128'(ctrl_cnt), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // Good PAUSE frame, then one with a flipped payload bit.
    run_frame(64, 1, 1'b0, 1'b0, 1'b0, -1, 2, 0);
    settle("pause");
    check("pause_ctrl_is_1", 128'(ctrl_cnt), 128'(1));
    run_frame(64, 1, 1'b1, 1'b0, 1'b0, -1, 2, 0);
    settle("pause_bad");
    // Runt, back-pressured frame and its successor, oversize frame.
    run_frame(12, 0, 1'b0, 1'b0, 1'b0, -1, 2, 0);
    settle("runt");
    check("runt_drop_is_1", 128'(drop_cnt), 128'(1));
    run_frame(100, 0, 1'b0, 1'b0, 1'b1, -1, 2, 0);
    run_frame(64, 0, 1'b0, 1'b0, 1'b0, -1, 2, 0);
    settle("afull");
    run_frame(2000, 0, 1'b0, 1'b0, 1'b0, -1, 2, 0);
    run_frame(MaxLen, 0, 1'b0, 1'b0, 1'b0, -1, 2, 0);
    run_frame(MaxLen + 1, 2, 1'b0, 1'b0, 1'b0, -1, 2, 0);
    run_frame(14, 0, 1'b0, 1'b0, 1'b0, -1, 2, 0);
    run_frame(15, 0, 1'b0, 1'b0, 1'b0, -1, 2, 0);
    settle("bounds");
    // Back-to-back: a byte during the header write is dropped with its whole frame.
    run_frame(64, 0, 1'b0, 1'b0, 1'b0, -1, 2, 0);
    run_frame(40, 1, 1'b0, 1'b0, 1'b0, -1, 0, 0);
    run_frame(64, 0, 1'b0, 1'b0, 1'b0, 20, 1, 0);
    settle("b2b");

    // Reset at byte 30: bytes 14..29 were already written, no header follows.
    build_frame(64, 0, 1'b0);
    for (int i = 14; i < 30; i++) exp_b.push_back({1'b0, frm[i]});
    exp_b_total += 16;
    for (int i = 0; i < 30; i++) drive_byte(frm[i], 1'b0, 1'b0, 1'b0, 1'b0);
    idle(0);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    m_drop = 0;
    m_ctrl = 0;
    check("midrst_drop", 128'(drop_cnt), 128'(0));
    check("midrst_ctrl", 128'(ctrl_cnt), 128'(0));
    frm = frm[30:$];
    prev_commit = model(1'b0, 1'b0);
    send_frame(1'b0, 1'b0, -1, 0, prev_commit);
    run_frame(64, 0, 1'b0, 1'b0, 1'b0, -1, 2, 0);
    settle("midrst");

    // Randomized traffic.
    for (int f = 0; f < 60; f++) begin
      case ($urandom_range(9))
        0:       len = $urandom_range(1, 20);
        1:       len = $urandom_range(MaxLen - 4, MaxLen + 4);
        default: len = $urandom_range(15, 130);
      endcase
      kind = $urandom_range(3);
      if (kind == 3) kind = 0;
      run_frame(len, kind, $urandom_range(4) == 0, $urandom_range(9) == 0,
                $urandom_range(9) == 0, ($urandom_range(9) == 0) ? $urandom_range(len - 1) : -1,
                ($urandom_range(6) == 0) ? 0 : $urandom_range(1, 3),
                (f % 2 == 1) ? 10 : 0);
    end
    settle("random");
    check("body_writes", 128'(obs_b), 128'(exp_b_total));
    check("hdr_writes", 128'(obs_h), 128'(exp_h_total));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
